// File: rtl/clock_enable.sv
// clock_enable
//   Enable-strobe generator for the 56 MHz master clock. A free-running 5-bit
//   counter is decoded into registered single-cycle strobes for the pixel
//   (7 MHz), CPU (3.5/7 MHz) and PSG (1.75 MHz) logic. The CPU strobes are
//   gated by ULA contention through a two-state RUN/STALL machine.
//
//   state | meaning
//   RUN   | CPU clock running, peCpu/neCpu issued at their slots
//   STALL | contention holding the CPU, cpuClk frozen high
//
// Ports
//   clock   in   56 MHz master clock, rising edge
//   reset   in   asynchronous active-low reset
//   contend in   ULA contention request (sampled at CPU rising slots only)
//   turbo   in   1 = CPU 7 MHz, 0 = 3.5 MHz
//   pe7M    out  7 MHz rising-phase strobe
//   ne7M    out  7 MHz falling-phase strobe
//   pe3M5   out  3.5 MHz rising-phase strobe (ungated)
//   ne3M5   out  3.5 MHz falling-phase strobe (ungated)
//   peCpu   out  CPU rising-edge enable (contention-gated)
//   neCpu   out  CPU falling-edge enable (contention-gated)
//   cpuClk  out  CPU clock level, observation only
//   ce1M75  out  PSG enable
//   stalled out  high while the CPU is held by contention
module clock_enable #(
  parameter int CW    = 5,
  parameter bit TURBO = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic contend,
  input  logic turbo,
  output logic pe7M,
  output logic ne7M,
  output logic pe3M5,
  output logic ne3M5,
  output logic peCpu,
  output logic neCpu,
  output logic cpuClk,
  output logic ce1M75,
  output logic stalled
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [CW-1:0] r_cnt;
  logic          r_tq;
  logic          r_fired;
  logic          r_pe7m;
  logic          r_ne7m;
  logic          r_pe3m5;
  logic          r_ne3m5;
  logic          r_ce1m75;
  logic          r_pe_cpu;
  logic          r_ne_cpu;
  logic          r_cpu_clk;
  logic          r_stalled;

  logic          w_rise;
  logic          w_fall;
  logic          w_pe_cpu_nxt;
  logic          w_ne_cpu_nxt;
  logic          w_tq_load;

  assign w_rise = r_tq ? (r_cnt[2:0] == 3'd7) : (r_cnt[3:0] == 4'd15);
  assign w_fall = r_tq ? (r_cnt[2:0] == 3'd3) : (r_cnt[3:0] == 4'd7);

  // Speed is only re-latched at cnt[3:0]==15, which is a rising slot in both
  // modes. Leaving turbo at a cnt[2:0]==7 slot that is not also a 3.5 MHz
  // rising slot would let the next 3.5 MHz rising slot arrive before the
  // matching falling slot and break peCpu/neCpu alternation.
  assign w_tq_load = TURBO && w_rise && (r_state == ST_RUN) && (r_cnt[3:0] == 4'd15);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pe_cpu_nxt = 1'b0;
    w_ne_cpu_nxt = 1'b0;
    if (w_rise) begin
      w_pe_cpu_nxt = ~contend;
      w_state_nxt  = contend ? ST_STALL : ST_RUN;
    end
    if (w_fall && (r_state == ST_RUN) && r_fired) begin
      w_ne_cpu_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_tq      <= 1'b0;
      r_fired   <= 1'b0;
      r_pe7m    <= 1'b0;
      r_ne7m    <= 1'b0;
      r_pe3m5   <= 1'b0;
      r_ne3m5   <= 1'b0;
      r_ce1m75  <= 1'b0;
      r_pe_cpu  <= 1'b0;
      r_ne_cpu  <= 1'b0;
      r_cpu_clk <= 1'b1;
      r_stalled <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + CW'(1);
      r_pe7m   <= (r_cnt[2:0] == 3'd7);
      r_ne7m   <= (r_cnt[2:0] == 3'd3);
      r_pe3m5  <= (r_cnt[3:0] == 4'd15);
      r_ne3m5  <= (r_cnt[3:0] == 4'd7);
      r_ce1m75 <= &r_cnt;
      r_pe_cpu <= w_pe_cpu_nxt;
      r_ne_cpu <= w_ne_cpu_nxt;

      // Every rising slot drives cpuClk high: either the CPU edge fires or
      // the clock freezes high for the stall.
      if (w_rise) begin
        r_fired   <= ~contend;
        r_cpu_clk <= 1'b1;
        r_stalled <= contend;
      end else if (w_fall) begin
        r_fired <= 1'b0;
        if (w_ne_cpu_nxt) begin
          r_cpu_clk <= 1'b0;
        end
      end

      if (w_tq_load) begin
        r_tq <= turbo;
      end
    end
  end

  assign pe7M    = r_pe7m;
  assign ne7M    = r_ne7m;
  assign pe3M5   = r_pe3m5;
  assign ne3M5   = r_ne3m5;
  assign ce1M75  = r_ce1m75;
  assign peCpu   = r_pe_cpu;
  assign neCpu   = r_ne_cpu;
  assign cpuClk  = r_cpu_clk;
  assign stalled = r_stalled;

endmodule

// File: tb/tb_clock_enable.sv
// tb_clock_enable
//   Directed bench for clock_enable. Output vector order used throughout:
//   {pe7M, ne7M, pe3M5, ne3M5, ce1M75, peCpu, neCpu, cpuClk, stalled}.
module tb_clock_enable;

  logic clock;
  logic reset;
  logic contend;
  logic turbo;
  logic pe7M, ne7M, pe3M5, ne3M5, peCpu, neCpu, cpuClk, ce1M75, stalled;
  logic [8:0] obs;

  int n_vec;
  int n_err;

  clock_enable #(.CW(5), .TURBO(1'b1)) dut (
    .clock  (clock),
    .reset  (reset),
    .contend(contend),
    .turbo  (turbo),
    .pe7M   (pe7M),
    .ne7M   (ne7M),
    .pe3M5  (pe3M5),
    .ne3M5  (ne3M5),
    .peCpu  (peCpu),
    .neCpu  (neCpu),
    .cpuClk (cpuClk),
    .ce1M75 (ce1M75),
    .stalled(stalled)
  );

  assign obs = {pe7M, ne7M, pe3M5, ne3M5, ce1M75, peCpu, neCpu, cpuClk, stalled};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         ncyc;
    logic       contend;
    logic       turbo;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[27];

  localparam logic [8:0] RESET_VAL = 9'b000000010;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      contend = vecs[i].contend;
      turbo   = vecs[i].turbo;
      step(vecs[i].ncyc);
      check($sformatf("vec%0d", i), int'(obs), int'(vecs[i].exp));
    end
  endtask

  initial begin
    int   last_pe_e;
    int   cnt_pe;
    int   cnt_ne;
    int   cnt_hi;
    int   gap_err;
    int   alt_err;
    int   per_err;
    bit   last_was_pe;
    bit   got;
    logic [8:0] exp_v;

    n_vec = 0;
    n_err = 0;

    // E = edges since reset release; outputs after edge E decode cnt=E-1.
    // Reset release, turbo=0, contend=0.
    vecs[0]  = '{1,  1'b0, 1'b0, 9'b000000010};  // E=1
    vecs[1]  = '{3,  1'b0, 1'b0, 9'b010000010};  // E=4   ne7M
    vecs[2]  = '{1,  1'b0, 1'b0, 9'b000000010};  // E=5
    vecs[3]  = '{3,  1'b0, 1'b0, 9'b100100010};  // E=8   pe7M ne3M5, no neCpu yet
    vecs[4]  = '{4,  1'b0, 1'b0, 9'b010000010};  // E=12
    vecs[5]  = '{4,  1'b0, 1'b0, 9'b101001010};  // E=16  first peCpu
    vecs[6]  = '{8,  1'b0, 1'b0, 9'b100100100};  // E=24  first neCpu
    vecs[7]  = '{1,  1'b0, 1'b0, 9'b000000000};  // E=25  cpuClk low
    vecs[8]  = '{3,  1'b0, 1'b0, 9'b010000000};  // E=28
    vecs[9]  = '{4,  1'b0, 1'b0, 9'b101011010};  // E=32  ce1M75
    vecs[10] = '{1,  1'b0, 1'b0, 9'b000000010};  // E=33
    // Contention across three rising slots (E=48,64,80), released at E=96.
    vecs[11] = '{7,  1'b1, 1'b0, 9'b100100100};  // E=40  falling slot unaffected
    vecs[12] = '{8,  1'b1, 1'b0, 9'b101000011};  // E=48  peCpu suppressed, stall
    vecs[13] = '{8,  1'b1, 1'b0, 9'b100100011};  // E=56  neCpu suppressed, clk high
    vecs[14] = '{8,  1'b1, 1'b0, 9'b101010011};  // E=64
    vecs[15] = '{16, 1'b1, 1'b0, 9'b101000011};  // E=80
    vecs[16] = '{16, 1'b0, 1'b0, 9'b101011010};  // E=96  released, peCpu
    vecs[17] = '{8,  1'b0, 1'b0, 9'b100100100};  // E=104 neCpu 8 later
    // Contend pulse entirely between rising slots.
    vecs[18] = '{7,  1'b1, 1'b0, 9'b000000000};  // E=111
    vecs[19] = '{1,  1'b0, 1'b0, 9'b101001010};  // E=112 peCpu not lost
    // Turbo raised mid half-period; latched at the E=128 rising slot.
    vecs[20] = '{8,  1'b0, 1'b1, 9'b100100100};  // E=120 still 3.5 MHz
    vecs[21] = '{8,  1'b0, 1'b1, 9'b101011010};  // E=128
    vecs[22] = '{4,  1'b0, 1'b1, 9'b010000100};  // E=132 neCpu after 4
    vecs[23] = '{4,  1'b0, 1'b1, 9'b100101010};  // E=136 peCpu after 8
    vecs[24] = '{1,  1'b0, 1'b1, 9'b000000010};  // E=137 no double pulse
    vecs[25] = '{3,  1'b0, 1'b1, 9'b010000100};  // E=140
    vecs[26] = '{4,  1'b0, 1'b1, 9'b101001010};  // E=144

    reset   = 1'b0;
    contend = 1'b0;
    turbo   = 1'b0;
    step(3);
    check("reset_state", int'(obs), int'(RESET_VAL));
    reset = 1'b1;

    apply_vecs(0, 26);

    // Turbo steady state: peCpu every 8 cycles over E=145..208.
    cnt_pe    = 0;
    cnt_ne    = 0;
    gap_err   = 0;
    last_pe_e = 144;
    for (int e = 145; e <= 208; e++) begin
      step(1);
      if (peCpu) begin
        cnt_pe++;
        if (e - last_pe_e != 8) gap_err++;
        last_pe_e = e;
      end
      if (neCpu) cnt_ne++;
    end
    check("turbo_pe_count", cnt_pe, 8);
    check("turbo_ne_count", cnt_ne, 8);
    check("turbo_pe_gap", gap_err, 0);

    // Enter STALL, then pulse reset while stalled.
    contend = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1);
      if (stalled) got = 1'b1;
    end
    check("stall_reached", int'(got), 1);
    check("stall_cpuclk", int'(cpuClk), 1);
    reset = 1'b0;
    #2;
    check("reset_async", int'(obs), int'(RESET_VAL));
    step(1);
    check("reset_held", int'(obs), int'(RESET_VAL));
    reset   = 1'b1;
    contend = 1'b0;
    turbo   = 1'b0;

    apply_vecs(0, 10);

    // Long run at 3.5 MHz from E=34: exact periods, CPU alternation, duty.
    per_err     = 0;
    alt_err     = 0;
    cnt_pe      = 0;
    cnt_ne      = 0;
    cnt_hi      = 0;
    last_was_pe = 1'b1;
    for (int e = 34; e < 34 + 960; e++) begin
      step(1);
      exp_v = {(e % 8) == 0, (e % 8) == 4, (e % 16) == 0, (e % 16) == 8,
               (e % 32) == 0, (e % 16) == 0, (e % 16) == 8, (e % 16) < 8, 1'b0};
      if (obs != exp_v) per_err++;
      if (peCpu) begin
        if (last_was_pe) alt_err++;
        last_was_pe = 1'b1;
      end
      if (neCpu) begin
        if (!last_was_pe) alt_err++;
        last_was_pe = 1'b0;
      end
      if (pe7M && ne7M) alt_err++;
      if (e < 34 + 320) begin
        if (peCpu) cnt_pe++;
        if (neCpu) cnt_ne++;
        if (cpuClk) cnt_hi++;
      end
    end
    check("period_errors", per_err, 0);
    check("alternation_errors", alt_err, 0);
    check("pe_cpu_320", cnt_pe, 20);
    check("ne_cpu_320", cnt_ne, 20);
    check("cpuclk_high_320", cnt_hi, 160);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
